// File: rtl/uart_mmio.sv
// Memory-mapped 8-bit UART: single-byte TX shifter, 4-entry RX FIFO, programmable baud divisor.
// Optional even parity on both directions when UART_PARITY_EN is defined.
module uart_mmio #(
  parameter int               DIV_W       = 12,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(103),
  parameter int               FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PAR,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PAR,
`endif
    RX_STOP
  } rx_state_t;

  logic             cs_q, rd_data_q;
  logic             wr_evt, pop_req;
  logic [DIV_W-1:0] div;
  logic             ovr, frm_err, par_err;

  tx_state_t        tx_state;
  logic [DIV_W-1:0] tx_cnt, tx_div;
  logic [7:0]       tx_sh;
  logic [2:0]       tx_bit;
  logic             tx_busy;

  rx_state_t        rx_state;
  logic             rx_s1, rx_s2, rx_prev;
  logic [DIV_W-1:0] rx_cnt, rx_div;
  logic [7:0]       rx_sh;
  logic [2:0]       rx_bit;
  logic             rx_push, rx_fe;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop, rx_valid, rx_full;

  logic             unused_din;
  assign unused_din = ^din[15:DIV_W];

  // Writes act on the cs rising edge; a DATA read pops on the following cs falling edge.
  assign wr_evt  = cs & ~cs_q & we;
  assign pop_req = ~cs & cs_q & rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q      <= 1'b0;
      rd_data_q <= 1'b0;
    end else begin
      cs_q <= cs;
      if (cs & ~cs_q) rd_data_q <= ~we & (addr == 2'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div <= DEFAULT_DIV;
    else if (wr_evt && addr == 2'd2) div <= din[DIV_W-1:0];
  end

  // ---------------- TX ----------------
  assign tx_busy = (tx_state != TX_IDLE);

`ifdef UART_PARITY_EN
  logic tx_par;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_par <= 1'b0;
    else if (tx_state == TX_IDLE && wr_evt && addr == 2'd0) tx_par <= ^din[7:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_sh    <= '0;
      tx_bit   <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (wr_evt && addr == 2'd0) begin
            tx_sh    <= din[7:0];
            tx_div   <= div;
            tx_cnt   <= div;
            txd      <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            txd      <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_bit   <= '0;
            tx_cnt   <= tx_div;
            tx_state <= TX_DATA;
          end else tx_cnt <= tx_cnt - DIV_W'(1);
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= tx_div;
            if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              txd      <= tx_par;
              tx_state <= TX_PAR;
`else
              txd      <= 1'b1;
              tx_state <= TX_STOP;
`endif
            end else begin
              txd    <= tx_sh[0];
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_bit <= tx_bit + 3'd1;
            end
          end else tx_cnt <= tx_cnt - DIV_W'(1);
        end
`ifdef UART_PARITY_EN
        TX_PAR: begin
          if (tx_cnt == '0) begin
            txd      <= 1'b1;
            tx_cnt   <= tx_div;
            tx_state <= TX_STOP;
          end else tx_cnt <= tx_cnt - DIV_W'(1);
        end
`endif
        TX_STOP: begin
          if (tx_cnt == '0) tx_state <= TX_IDLE;
          else tx_cnt <= tx_cnt - DIV_W'(1);
        end
        default: begin
          txd      <= 1'b1;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

`ifdef UART_PARITY_EN
  logic rx_par_bad, rx_pe;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_sh    <= '0;
      rx_bit   <= '0;
      rx_push  <= 1'b0;
      rx_fe    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad <= 1'b0;
      rx_pe      <= 1'b0;
`endif
    end else begin
      rx_push <= 1'b0;
      rx_fe   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_pe   <= 1'b0;
`endif
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev & ~rx_s2) begin
            rx_div   <= div;
            rx_cnt   <= div >> 1;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rx_s2) rx_state <= RX_IDLE;
            else begin
              rx_cnt   <= rx_div;
              rx_bit   <= '0;
              rx_state <= RX_DATA;
            end
          end else rx_cnt <= rx_cnt - DIV_W'(1);
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= rx_div;
            if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state <= RX_PAR;
`else
              rx_state <= RX_STOP;
`endif
            end else rx_bit <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt - DIV_W'(1);
        end
`ifdef UART_PARITY_EN
        RX_PAR: begin
          if (rx_cnt == '0) begin
            rx_par_bad <= ^{rx_sh, rx_s2};
            rx_cnt     <= rx_div;
            rx_state   <= RX_STOP;
          end else rx_cnt <= rx_cnt - DIV_W'(1);
        end
`endif
        RX_STOP: begin
          if (rx_cnt == '0) begin
            rx_state <= RX_IDLE;
            if (!rx_s2) rx_fe <= 1'b1;
`ifdef UART_PARITY_EN
            else if (rx_par_bad) rx_pe <= 1'b1;
`endif
            else rx_push <= 1'b1;
          end else rx_cnt <= rx_cnt - DIV_W'(1);
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- FIFO and flags ----------------
  assign rx_valid = (count != '0);
  assign rx_full  = (count == CW'(FIFO_DEPTH));
  assign do_pop   = pop_req & rx_valid;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push  = rx_push & (~rx_full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= rx_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      if (rx_push & ~do_push) ovr <= 1'b1;
      else if (wr_evt && addr == 2'd1 && din[3]) ovr <= 1'b0;
      if (rx_fe) frm_err <= 1'b1;
      else if (wr_evt && addr == 2'd1 && din[4]) frm_err <= 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else if (rx_pe) par_err <= 1'b1;
    else if (wr_evt && addr == 2'd1 && din[5]) par_err <= 1'b0;
  end
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    dout = '0;
    if (cs) begin
      case (addr)
        2'd0:    if (rx_valid) dout[7:0] = mem[rptr];
        2'd1:    dout[5:0] = {par_err, frm_err, ovr, rx_full, rx_valid, tx_busy};
        2'd2:    dout[DIV_W-1:0] = div;
        default: dout = '0;
      endcase
    end
  end

  assign irq = rx_valid | ovr | frm_err | par_err;

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: bus accesses, TX bit timing, loopback RX, FIFO overrun, error flags.
// RX bytes are checked against a scoreboard queue filled as frames are sent.
module tb_uart_mmio;

`ifdef UART_PARITY_EN
  localparam int FRAME_N = 11;
`else
  localparam int FRAME_N = 10;
`endif

  logic        clk, rst_n, cs, we, txd, rxd, irq, rxd_drv, loop_en;
  logic [1:0]  addr;
  logic [15:0] din, dout, d;
  int          checks, errors;
  logic [7:0]  exp_q[$];
  logic        exp_ovr;

  uart_mmio #(.DIV_W(12), .DEFAULT_DIV(12'd103), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .txd(txd), .rxd(rxd), .irq(irq)
  );

  assign rxd = loop_en ? txd : rxd_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] v);
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = a; din = v;
    @(negedge clk); cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] v);
    @(negedge clk); cs = 1'b1; we = 1'b0; addr = a;
    #1 v = dout;
    @(negedge clk); cs = 1'b0;
  endtask

  task automatic send_rx(input logic [10:0] bits);
    for (int i = 0; i < FRAME_N; i++) begin
      rxd_drv = bits[i];
      repeat (4) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b, input logic stp);
`ifdef UART_PARITY_EN
    return {stp, ^b, b, 1'b0};
`else
    return {1'b0, stp, b, 1'b0};
`endif
  endfunction

  function automatic logic exp_tx_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  initial begin
    logic [7:0] lb [3];
    logic [7:0] ob [5];
    lb = '{8'h00, 8'hFF, 8'h5A};
    ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    checks = 0; errors = 0; exp_ovr = 1'b0;
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; addr = 2'd0; din = '0;
    rxd_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_txd", 16'(txd), 16'h1);
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_dout_idle", dout, 16'h0);
    rd(2'd1, d); chk("rst_status", d, 16'h0000);
    rd(2'd2, d); chk("rst_baud", d, 16'd103);
    wr(2'd2, 16'h0003);
    rd(2'd2, d); chk("baud_wr", d, 16'd3);

    // TX frame of A5 with a mid-frame write and busy checks
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = 2'd0; din = 16'h00A5;
    for (int k = 1; k <= FRAME_N*4 + 4; k++) begin
      @(negedge clk);
      if (k <= FRAME_N*4 + 1) chk("tx_bit", 16'(txd), 16'(exp_tx_bit(8'hA5, (k-1)/4)));
      if (k == 1 || k == 11 || k == 21 || k == FRAME_N*4 + 3) begin cs = 1'b0; we = 1'b0; end
      if (k == 10) begin cs = 1'b1; we = 1'b1; addr = 2'd0; din = 16'h0000; end
      if (k == 20) begin cs = 1'b1; we = 1'b0; addr = 2'd1; #1 chk("tx_busy_mid", dout, 16'h0001); end
      if (k == FRAME_N*4 + 2) begin cs = 1'b1; we = 1'b0; addr = 2'd1; #1 chk("tx_busy_end", dout, 16'h0000); end
    end

    // Loopback of three bytes
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr(2'd0, {8'h00, lb[i]});
      exp_q.push_back(lb[i]);
      repeat (FRAME_N*4 + 12) @(negedge clk);
    end
    loop_en = 1'b0;
    rd(2'd1, d); chk("loop_status", d, 16'h0002);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      rd(2'd0, d); chk("loop_data", d, {8'h00, e});
    end
    rd(2'd1, d); chk("loop_drained", d, 16'h0000);
    rd(2'd0, d); chk("empty_read", d, 16'h0000);

    // Five frames without reads: FIFO fills, fifth overruns
    for (int i = 0; i < 5; i++) begin
      send_rx(frame_of(ob[i], 1'b1));
      if (exp_q.size() < 4) exp_q.push_back(ob[i]);
      else exp_ovr = 1'b1;
    end
    rd(2'd1, d); chk("ovr_status", d, {12'h0, exp_ovr, 3'b110});
    chk("ovr_irq", 16'(irq), 16'h1);
    wr(2'd1, 16'h0008);
    rd(2'd1, d); chk("ovr_cleared", d, 16'h0006);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      rd(2'd0, d); chk("fifo_data", d, {8'h00, e});
    end
    rd(2'd1, d); chk("fifo_drained", d, 16'h0000);
    chk("irq_clear", 16'(irq), 16'h0);

    // One-clock glitch, then a frame with a low stop bit
    @(negedge clk); rxd_drv = 1'b0;
    @(negedge clk); rxd_drv = 1'b1;
    repeat (20) @(negedge clk);
    rd(2'd1, d); chk("glitch_status", d, 16'h0000);
    send_rx(frame_of(8'h3C, 1'b0));
    rd(2'd1, d); chk("frame_err", d, 16'h0010);
    chk("frame_irq", 16'(irq), 16'h1);
    wr(2'd1, 16'h0010);
    rd(2'd1, d); chk("frame_cleared", d, 16'h0000);

`ifdef UART_PARITY_EN
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = 2'd0; din = 16'h0007;
    for (int k = 1; k <= FRAME_N*4 + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin cs = 1'b0; we = 1'b0; end
      chk("par_tx_bit", 16'(txd), 16'(exp_tx_bit(8'h07, (k-1)/4)));
    end
    repeat (4) @(negedge clk);
    send_rx({1'b1, 1'b0, 8'h07, 1'b0});
    rd(2'd1, d); chk("parity_err", d, 16'h0020);
    wr(2'd1, 16'h0020);
    rd(2'd1, d); chk("parity_cleared", d, 16'h0000);
`endif

    // Reset mid-frame: txd must rise without waiting for a clock
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = 2'd0; din = 16'h0000;
    @(negedge clk); cs = 1'b0; we = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_frame_txd", 16'(txd), 16'h0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_txd", 16'(txd), 16'h1);
    @(negedge clk); rst_n = 1'b1;
    rd(2'd2, d); chk("rst2_baud", d, 16'd103);
    rd(2'd1, d); chk("rst2_status", d, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
